// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues reads to instruction memory and
// buffers returned words in a small prefetch FIFO that feeds decode over valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        misalign_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    entry_t          head_q, head_d;
    entry_t          push_entry;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    logic            inflight_valid_q, inflight_valid_d;
    logic            misalign_err_q, misalign_err_d;
    logic            push, pop, issue;
    logic [OW-1:0]   occupancy;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        fetch_pc_d       = fetch_pc_q;
        inflight_pc_d    = inflight_pc_q;
        inflight_valid_d = 1'b0;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        head_d           = head_q;
        misalign_err_d   = misalign_err_q | (redirect && (redirect_pc[1:0] != 2'b00));

        pop        = (count_q != '0) && instr_ready;
        push       = inflight_valid_q && !redirect && !rst;
        push_entry = '{pc: inflight_pc_q, instr: imem_rdata};

        // Credit check counts the word already in flight so a push never meets a full FIFO.
        occupancy = {1'b0, count_q} + OW'(inflight_valid_q) - OW'(pop);
        issue     = !rst && !redirect && (occupancy < OW'(DEPTH));

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (issue) begin
                inflight_valid_d = 1'b1;
                inflight_pc_d    = fetch_pc_q;
                fetch_pc_d       = fetch_pc_q + 32'd4;
            end
        end

        // Registered head keeps the last word visible while empty; the new head may be
        // the word written this cycle, which the storage array does not yet hold.
        if (count_d != '0) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                head_d = push_entry;
            end else begin
                head_d = fifo_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
        if (rst) begin
            fetch_pc_q       <= RESET_PC;
            inflight_pc_q    <= '0;
            inflight_valid_q <= 1'b0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            head_q           <= '0;
            misalign_err_q   <= 1'b0;
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_valid_q <= inflight_valid_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            head_q           <= head_d;
            misalign_err_q   <= misalign_err_d;
        end
    end

    // NOTE: storage is not reset; count gates every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    assign imem_addr    = fetch_pc_q;
    assign imem_en      = issue;
    assign instr_valid  = (count_q != '0);
    assign instruction  = head_q.instr;
    assign instr_pc     = head_q.pc;
    assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus queues expected PCs, a negedge monitor pops and
// compares every accepted instruction. Memory model returns word == address.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        misalign_err;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_en      (imem_en),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instruction  (instruction),
        .instr_pc     (instr_pc),
        .misalign_err (misalign_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle-latency instruction memory; garbage when not enabled exposes stray pushes.
    always @(posedge clk) begin
        imem_rdata <= imem_en ? imem_addr : 32'hBAD0_BAD0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got pc %h, expected no output at %0t", instr_pc, $time);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_pc", instr_pc, e);
                check("sb_instr", instruction, e);
            end
        end
        if (dut.count_q > 2) begin
            n_err++;
            $display("FAIL fifo_overflow: count %0d exceeds depth 2", dut.count_q);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        instr_ready = 1'b1;
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            step();
        end
        instr_ready = 1'b0;
        check("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        step();
        redirect    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;

        // Reset values, then first instruction two cycles after release.
        step();
        check("en_in_reset", 32'(imem_en), 32'd0);
        step();
        rst = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        instr_ready = 1'b1;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instruction, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        step();
        check("valid_cycle1", 32'(instr_valid), 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            check("stream_valid", 32'(instr_valid), 32'd1);
            check("stream_pc", instr_pc, 32'(4 * k));
            step();
        end
        instr_ready = 1'b0;
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // Stall: head holds, fetch stops once full, stream resumes contiguously.
        for (int k = 0; k < 10; k++) begin
            check("stall_head", instr_pc, 32'h10);
            check("stall_valid", 32'(instr_valid), 32'd1);
            step();
        end
        check("stall_en", 32'(imem_en), 32'd0);
        for (int a = 16; a <= 28; a += 4) exp_q.push_back(32'(a));
        drain(20);

        // Redirect while full.
        step();
        step();
        step();
        check("full_en", 32'(imem_en), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check("redir_en", 32'(imem_en), 32'd0);
        step();
        redirect = 1'b0;
        #1;
        check("redir_valid", 32'(instr_valid), 32'd0);
        check("redir_addr", imem_addr, 32'h40);
        check("redir_en_next", 32'(imem_en), 32'd1);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        step();
        check("redir_valid2", 32'(instr_valid), 32'd0);
        step();
        check("redir_valid3", 32'(instr_valid), 32'd1);
        check("redir_pc3", instr_pc, 32'h40);
        drain(20);

        // Redirect with a word in flight: stale words must never surface.
        redirect_to(32'h100);
        check("inflight_valid", 32'(instr_valid), 32'd0);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        drain(20);

        // Reset mid-stream with head at 0x20.
        redirect_to(32'h10);
        for (int a = 16; a <= 28; a += 4) exp_q.push_back(32'(a));
        drain(20);
        check("mid_head", instr_pc, 32'h20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_pc", instr_pc, 32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        drain(20);

        // Misaligned target, sticky error, back-to-back redirects, address wrap.
        redirect_to(32'h42);
        check("mis_addr", imem_addr, 32'h40);
        check("mis_err", 32'(misalign_err), 32'd1);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        drain(20);
        for (int k = 0; k < 5; k++) begin
            redirect    = 1'b1;
            redirect_pc = 32'h200 + 32'(k) * 32'h100;
            step();
        end
        redirect = 1'b0;
        check("b2b_addr", imem_addr, 32'h600);
        check("b2b_err", 32'(misalign_err), 32'd1);
        exp_q.push_back(32'h600);
        exp_q.push_back(32'h604);
        drain(20);
        redirect_to(32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        drain(20);
        check("wrap_err", 32'(misalign_err), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("err_cleared", 32'(misalign_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
